fir_result_buffer: RTL



---
 rtl/fir_result_buffer_pkg.sv | 23 ++
 rtl/fir_result_buffer_sync_fifo.sv | 60 ++++++
 rtl/fir_result_buffer.sv | 87 ++++++++
 3 files changed

// File: rtl/fir_result_buffer_pkg.sv
// Shared constants and types for the FIR result buffer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RESULT_FIFO_DEPTH
`define RESULT_FIFO_DEPTH 8
`endif
`ifndef DROP_CNT_W
`define DROP_CNT_W 8
`endif

package fir_result_buffer_pkg;
  localparam int unsigned DROP_CNT_W = `DROP_CNT_W;

  typedef logic [DROP_CNT_W-1:0] dropCnt_t;

  localparam dropCnt_t DROP_SAT = '1;

  // Saturating increment for the drop counter.
  function automatic dropCnt_t satInc(input dropCnt_t val);
    return (val == DROP_SAT) ? DROP_SAT : val + dropCnt_t'(1);
  endfunction
endpackage

// File: rtl/fir_result_buffer_sync_fifo.sv
// Synchronous FIFO with separate fill counter and registered write (no fall-through).
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic                  wrEn;
  logic                  rdEn;

  // Status flags and gated push/pop; a full FIFO still takes a push when a pop frees a slot.
  always_comb begin
    full  = (level == LVL_W'(DEPTH));
    empty = (level == '0);
    rdEn  = pop && !empty;
    wrEn  = push && (!full || rdEn);
    rdata = empty ? '0 : mem[rdPtr];
  end

  // Pointer and fill-level bookkeeping; flush has priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PTR_W'(1);
      if (rdEn) rdPtr <= rdPtr + PTR_W'(1);
      case ({wrEn, rdEn})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (wrEn && !flush) mem[wrPtr] <= wdata;
  end
endmodule

// File: rtl/fir_result_buffer.sv
// FIR result buffer: decimation, FIFO queueing, overflow flag and drop counter.
module fir_result_buffer
  import fir_result_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned DEPTH      = `RESULT_FIFO_DEPTH,
  parameter int unsigned DECIM_W    = 4,
  parameter int unsigned AFULL_LVL  = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inValid,
  input  logic [DATA_WIDTH-1:0]      inData,
  input  logic [DECIM_W-1:0]         decimFactor,
  input  logic                       flush,
  output logic                       outValid,
  output logic [DATA_WIDTH-1:0]      outData,
  input  logic                       outReady,
  output logic [$clog2(DEPTH+1)-1:0] fillLevel,
  output logic                       almostFull,
  output logic                       overflow,
  output logic [DROP_CNT_W-1:0]      dropCount
);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0] AFULL = LVL_W'(AFULL_LVL);

  logic [DECIM_W-1:0] decCnt;
  logic [DECIM_W-1:0] factor;
  logic [DECIM_W-1:0] lastCnt;
  logic               keep;
  logic               pop;
  logic               drop;
  logic               full;
  logic               empty;

  // Keep/drop decisions; a factor of 0 behaves like 1.
  always_comb begin
    factor     = (decimFactor == '0) ? DECIM_W'(1) : decimFactor;
    lastCnt    = factor - DECIM_W'(1);
    keep       = inValid && (decCnt == '0);
    pop        = !empty && outReady;
    drop       = keep && full && !pop && !flush;
    outValid   = !empty;
    almostFull = (fillLevel >= AFULL);
  end

  // Decimation counter; out-of-range values wrap to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decCnt <= '0;
    end else if (flush) begin
      decCnt <= '0;
    end else if (inValid) begin
      decCnt <= (factor <= DECIM_W'(1) || decCnt >= lastCnt) ? '0 : decCnt + DECIM_W'(1);
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      dropCount <= '0;
    end else if (flush) begin
      overflow  <= 1'b0;
      dropCount <= '0;
    end else if (drop) begin
      overflow  <= 1'b1;
      dropCount <= satInc(dropCount);
    end
  end

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) uFifo (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (keep),
    .pop  (pop),
    .wdata(inData),
    .rdata(outData),
    .full (full),
    .empty(empty),
    .level(fillLevel)
  );
endmodule
